// File: rtl/change_dispenser_pkg.sv
// -----------------------------------------------------------------------------
// machine_pkg
// Shared definitions for the coin-vending machine and its payout stage.
//   disp_state_t : payout FSM states
//   COIN_UNIT    : value of one refunded coin (currency units)
//   CHANGE_W     : width of the change count handed over by the machine
//   max3()       : largest of three interval lengths, used to size the timer
// -----------------------------------------------------------------------------
package machine_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PULSE    = 3'd1,
    WAIT_ACK = 3'd2,
    GAP      = 3'd3,
    FAULT    = 3'd4
  } disp_state_t;

  localparam int COIN_UNIT = 5;
  localparam int CHANGE_W  = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

endpackage

// File: rtl/change_dispenser_timer.sv
// -----------------------------------------------------------------------------
// dispense_timer
// Loadable down-counter shared by the PULSE, WAIT_ACK and GAP intervals.
// A load value of N-1 makes zero assert on the N-th cycle after the load edge.
// Ports:
//   clk      in  : clock, rising edge
//   reset    in  : asynchronous active-low reset
//   load     in  : load load_val on the next edge (takes priority)
//   load_val in  : reload value (interval length minus one)
//   zero     out : counter has reached zero (holds there)
// -----------------------------------------------------------------------------
module dispense_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_r;

  // Counter register: reload on state entry, otherwise count down to zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= {W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != {W{1'b0}}) begin
      cnt_r <= cnt_r - ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/change_dispenser.sv
// -----------------------------------------------------------------------------
// change_dispenser
// Payout stage behind the vending machine. Accumulates refunds (in coins) from
// done/change strobes and ejects them one at a time through a hopper using a
// timed coin_out pulse answered by hopper_ack. A missing ack latches fault
// until fault_clr; owed coins are kept so payout resumes afterwards.
// Optional feature macro: CHANGE_DISPENSER_RETRY_EN -- when defined, the first
// ack timeout for a coin re-issues the pulse once before faulting.
// Ports:
//   clk        in  : clock, rising edge
//   reset      in  : asynchronous active-low reset
//   done       in  : sale-complete strobe
//   change     in  : coins owed, sampled when done=1
//   hopper_ack in  : coin-exit sensor pulse
//   fault_clr  in  : clears a latched fault
//   coin_out   out : hopper eject command
//   busy       out : state not IDLE or coins still owed
//   pending    out : coins still owed
//   fault      out : hopper timeout latched
//   ovf        out : sticky, pending counter saturated
// -----------------------------------------------------------------------------
module change_dispenser
  import machine_pkg::*;
#(
  parameter int PULSE_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 8,
  parameter int GAP_CYCLES     = 1,
  parameter int PEND_W         = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                done,
  input  logic [CHANGE_W-1:0] change,
  input  logic                hopper_ack,
  input  logic                fault_clr,
  output logic                coin_out,
  output logic                busy,
  output logic [PEND_W-1:0]   pending,
  output logic                fault,
  output logic                ovf
);

  localparam int TMAX = max3(PULSE_CYCLES, TIMEOUT_CYCLES, GAP_CYCLES);
  // Largest load value is TMAX-1, so clog2(TMAX) bits suffice.
  localparam int TW = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0]   PULSE_LD = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0]   WAIT_LD  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]   GAP_LD   = TW'(GAP_CYCLES - 1);
  localparam logic [PEND_W:0] PEND_MAX = {1'b0, {PEND_W{1'b1}}};
  localparam logic [PEND_W:0] PEND_ONE = (PEND_W + 1)'(1);

  disp_state_t       state_r;
  disp_state_t       state_next_s;
  logic [PEND_W-1:0] pending_r;
  logic              ovf_r;
  logic              timer_load_s;
  logic [TW-1:0]     timer_val_s;
  logic              timer_zero_s;
  logic              ack_take_s;
  logic [PEND_W:0]   pend_add_s;
  logic [PEND_W:0]   pend_sum_s;
  logic [PEND_W-1:0] pend_next_s;
  logic              pend_sat_s;

`ifdef CHANGE_DISPENSER_RETRY_EN
  logic retry_r;
`endif

  // An ack only counts while waiting for one.
  assign ack_take_s = (state_r == WAIT_ACK) && hopper_ack;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; an ack on the timeout cycle wins over the timeout.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (pending_r != {PEND_W{1'b0}}) state_next_s = PULSE;
        else                             state_next_s = IDLE;
      end
      PULSE: begin
        if (timer_zero_s) state_next_s = WAIT_ACK;
        else              state_next_s = PULSE;
      end
      WAIT_ACK: begin
        if (hopper_ack) begin
          state_next_s = GAP;
        end else if (timer_zero_s) begin
`ifdef CHANGE_DISPENSER_RETRY_EN
          if (!retry_r) state_next_s = PULSE;
          else          state_next_s = FAULT;
`else
          state_next_s = FAULT;
`endif
        end else begin
          state_next_s = WAIT_ACK;
        end
      end
      GAP: begin
        if (timer_zero_s) state_next_s = IDLE;
        else              state_next_s = GAP;
      end
      FAULT: begin
        if (fault_clr) state_next_s = IDLE;
        else           state_next_s = FAULT;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Timer reload: every state change loads the interval of the state entered.
  always_comb begin
    timer_load_s = (state_next_s != state_r);
    case (state_next_s)
      PULSE:    timer_val_s = PULSE_LD;
      WAIT_ACK: timer_val_s = WAIT_LD;
      GAP:      timer_val_s = GAP_LD;
      default:  timer_val_s = {TW{1'b0}};
    endcase
  end

  dispense_timer #(
    .W(TW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load_s),
    .load_val (timer_val_s),
    .zero     (timer_zero_s)
  );

`ifdef CHANGE_DISPENSER_RETRY_EN
  // Retry flag: set by the first timeout of a coin, cleared by ack or fault_clr.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retry_r <= 1'b0;
    end else if ((state_r == WAIT_ACK) && !hopper_ack && timer_zero_s && !retry_r) begin
      retry_r <= 1'b1;
    end else if (ack_take_s || ((state_r == FAULT) && fault_clr)) begin
      retry_r <= 1'b0;
    end else begin
      retry_r <= retry_r;
    end
  end
`endif

  // Pending update: add new change, subtract an accepted coin, then saturate.
  // Sum is one bit wider so the clip can be detected; pending>=1 in WAIT_ACK,
  // so the subtraction never underflows.
  always_comb begin
    pend_add_s = {(PEND_W + 1){1'b0}};
    if (done) begin
      pend_add_s = {{(PEND_W + 1 - CHANGE_W){1'b0}}, change};
    end else begin
      pend_add_s = {(PEND_W + 1){1'b0}};
    end
    pend_sum_s = {1'b0, pending_r} + pend_add_s;
    if (ack_take_s) begin
      pend_sum_s = pend_sum_s - PEND_ONE;
    end else begin
      pend_sum_s = pend_sum_s;
    end
    pend_sat_s = (pend_sum_s > PEND_MAX);
    if (pend_sat_s) begin
      pend_next_s = {PEND_W{1'b1}};
    end else begin
      pend_next_s = pend_sum_s[PEND_W-1:0];
    end
  end

  // Pending counter and sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_r <= {PEND_W{1'b0}};
      ovf_r     <= 1'b0;
    end else begin
      pending_r <= pend_next_s;
      ovf_r     <= ovf_r | pend_sat_s;
    end
  end

  // Outputs decoded straight from registers; reset clears them asynchronously.
  always_comb begin
    coin_out = (state_r == PULSE);
    fault    = (state_r == FAULT);
    busy     = (state_r != IDLE) || (pending_r != {PEND_W{1'b0}});
    pending  = pending_r;
    ovf      = ovf_r;
  end

endmodule

// File: tb/tb_change_dispenser.sv
// -----------------------------------------------------------------------------
// tb_change_dispenser
// Directed self-checking bench for change_dispenser with default parameters
// (PULSE_CYCLES=2, TIMEOUT_CYCLES=8, GAP_CYCLES=1, PEND_W=4). Inputs change
// 1 ns after a rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_change_dispenser;

  logic       clk;
  logic       reset;
  logic       done;
  logic [1:0] change;
  logic       hopper_ack;
  logic       fault_clr;
  logic       coin_out;
  logic       busy;
  logic [3:0] pending;
  logic       fault;
  logic       ovf;

  int checks   = 0;
  int failures = 0;

  change_dispenser #(
    .PULSE_CYCLES   (2),
    .TIMEOUT_CYCLES (8),
    .GAP_CYCLES     (1),
    .PEND_W         (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .done       (done),
    .change     (change),
    .hopper_ack (hopper_ack),
    .fault_clr  (fault_clr),
    .coin_out   (coin_out),
    .busy       (busy),
    .pending    (pending),
    .fault      (fault),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_coin"}, {31'd0, coin_out}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_pend"}, {28'd0, pending}, 32'd0);
    chk({tag, "_fault"}, {31'd0, fault}, 32'd0);
    chk({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
  endtask

  initial begin
    reset      = 1'b0;
    done       = 1'b0;
    change     = 2'd0;
    hopper_ack = 1'b0;
    fault_clr  = 1'b0;
    #12;
    chk_reset_vals("rst");
    reset = 1'b1;

    // One coin, ack in the first WAIT_ACK cycle.
    done = 1'b1; change = 2'd1;
    tick(); done = 1'b0; change = 2'd0;
    chk("t1_pend1", {28'd0, pending}, 32'd1);
    chk("t1_busy1", {31'd0, busy}, 32'd1);
    chk("t1_coin_idle", {31'd0, coin_out}, 32'd0);
    tick(); chk("t1_coin_a", {31'd0, coin_out}, 32'd1);
    tick(); chk("t1_coin_b", {31'd0, coin_out}, 32'd1);
    tick(); chk("t1_coin_fall", {31'd0, coin_out}, 32'd0);
    chk("t1_pend_wait", {28'd0, pending}, 32'd1);
    hopper_ack = 1'b1;
    tick(); hopper_ack = 1'b0;
    chk("t1_pend0", {28'd0, pending}, 32'd0);
    chk("t1_busy_gap", {31'd0, busy}, 32'd1);
    tick(); chk("t1_busy_idle", {31'd0, busy}, 32'd0);

    // Three coins with prompt acks: pulses 5 cycles apart.
    done = 1'b1; change = 2'd3;
    tick(); done = 1'b0; change = 2'd0;
    chk("t2_pend3", {28'd0, pending}, 32'd3);
    for (int k = 0; k < 3; k++) begin
      tick(); chk($sformatf("t2_c%0d_p1", k), {31'd0, coin_out}, 32'd1);
      tick(); chk($sformatf("t2_c%0d_p2", k), {31'd0, coin_out}, 32'd1);
      tick(); chk($sformatf("t2_c%0d_wait", k), {31'd0, coin_out}, 32'd0);
      hopper_ack = 1'b1;
      tick(); hopper_ack = 1'b0;
      chk($sformatf("t2_c%0d_pend", k), {28'd0, pending}, 32'(2 - k));
      tick(); chk($sformatf("t2_c%0d_idle", k), {31'd0, coin_out}, 32'd0);
    end
    chk("t2_busy_end", {31'd0, busy}, 32'd0);

    // done with change=0 does nothing.
    done = 1'b1; change = 2'd0;
    tick(); done = 1'b0;
    chk("t0_pend", {28'd0, pending}, 32'd0);
    tick(); chk("t0_coin", {31'd0, coin_out}, 32'd0);

    // No ack: timeout after 8 WAIT_ACK cycles.
    done = 1'b1; change = 2'd1;
    tick(); done = 1'b0; change = 2'd0;
    tick(); chk("t3_coin", {31'd0, coin_out}, 32'd1);
    tick();
    tick(); chk("t3_wait", {31'd0, coin_out}, 32'd0);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("t3_nofault%0d", i), {31'd0, fault}, 32'd0);
    end
    tick();
`ifdef CHANGE_DISPENSER_RETRY_EN
    chk("t4_retry_coin", {31'd0, coin_out}, 32'd1);
    chk("t4_retry_nofault", {31'd0, fault}, 32'd0);
    tick();
    tick(); chk("t4_retry_wait", {31'd0, coin_out}, 32'd0);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("t4_nofault%0d", i), {31'd0, fault}, 32'd0);
    end
    tick();
`endif
    chk("t3_fault", {31'd0, fault}, 32'd1);
    chk("t3_fault_coin", {31'd0, coin_out}, 32'd0);
    chk("t3_fault_pend", {28'd0, pending}, 32'd1);
    chk("t3_fault_busy", {31'd0, busy}, 32'd1);
    // Ack outside WAIT_ACK is ignored.
    hopper_ack = 1'b1;
    tick(); hopper_ack = 1'b0;
    chk("t3_ignack_pend", {28'd0, pending}, 32'd1);
    chk("t3_ignack_fault", {31'd0, fault}, 32'd1);
    fault_clr = 1'b1;
    tick(); fault_clr = 1'b0;
    chk("t3_clr_fault", {31'd0, fault}, 32'd0);
    tick(); chk("t3_resume_coin", {31'd0, coin_out}, 32'd1);
    tick();
    tick(); hopper_ack = 1'b1;
    tick(); hopper_ack = 1'b0;
    chk("t3_resume_pend", {28'd0, pending}, 32'd0);
    tick(); chk("t3_resume_busy", {31'd0, busy}, 32'd0);

    // Saturation: six done strobes of 3 coins, no acks.
    done = 1'b1; change = 2'd3;
    for (int i = 0; i < 6; i++) begin
      tick();
    end
    done = 1'b0; change = 2'd0;
    chk("t5_pend_sat", {28'd0, pending}, 32'd15);
    chk("t5_ovf", {31'd0, ovf}, 32'd1);
    reset = 1'b0;
    #2;
    chk_reset_vals("t5_rst");
    reset = 1'b1;

    // Coincident done and ack in WAIT_ACK.
    done = 1'b1; change = 2'd2;
    tick(); done = 1'b0; change = 2'd0;
    chk("t6_pend2", {28'd0, pending}, 32'd2);
    tick();
    tick();
    tick(); chk("t6_wait", {31'd0, coin_out}, 32'd0);
    done = 1'b1; change = 2'd2; hopper_ack = 1'b1;
    tick(); done = 1'b0; change = 2'd0; hopper_ack = 1'b0;
    chk("t6_pend3", {28'd0, pending}, 32'd3);
    tick();
    tick(); chk("t6_pulse", {31'd0, coin_out}, 32'd1);
    // Reset mid-PULSE drops coin_out at once.
    #2 reset = 1'b0;
    #1;
    chk_reset_vals("t6_rst");
    reset = 1'b1;
    tick();
    tick(); chk("t6_post_coin", {31'd0, coin_out}, 32'd0);
    chk("t6_post_busy", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
